access_code_entry: RTL and testbench
====================================

// Module: access_code_entry
// PURPOSE
//  Keypad front-end for the metro access gate. Collects decimal digits from the keypad
//  scanner, assembles them into a binary access code and hands it to the door FSM as
//  a one-cycle validate_code pulse with access_code held stable. Sits directly upstream
//  of the door FSM, and door_busy is driven from that FSM's open_access_door output.
// PARAMETERS
//  CODE_W       4    width of access_code; legal code range 0..2^CODE_W-1
//  MAX_DIGITS   2    max digits per entry
//  TIMEOUT_CYC  255  idle cycles between keys in COLLECT before the entry is aborted
//  HOLD_CYC     4    cycles keys are ignored after validate_code; covers downstream CHECK_CODE
// PORTS
//  clk           in   1       clock
//  reset_n       in   1       async reset, active-low
//  key_valid     in   1       one-cycle strobe: key_code valid
//  key_code      in   4       0-9 digit, 4'hA CLEAR, 4'hB ENTER, 4'hC-F ignored
//  door_busy     in   1       door open downstream; blocks entry start and code hand-off
//  validate_code out  1       one-cycle pulse: access_code is valid
//  access_code   out  CODE_W  last submitted code, held until next validate_code
//  entry_error   out  1       one-cycle pulse: overflow, excess digit or timeout
//  state_out     out  2       FSM state, debug only
// BEHAVIOUR
//  - Reset (async): state IDLE; validate_code=0, access_code=0, entry_error=0;
//    acc, digit count, overflow flag and timer cleared. All outputs registered.
//  - Reset asserted mid-entry drops the partial code; no pulse is emitted.
//  - States: IDLE=0, COLLECT=1, SEND=2, HOLD=3.
//  - IDLE: digit with door_busy=0 -> acc=digit, cnt=1, COLLECT. All keys ignored while
//    door_busy=1. CLEAR, ENTER and codes C-F are ignored.
//  - COLLECT, digit with cnt<MAX_DIGITS: acc=acc*10+digit, cnt++, timer cleared.
//    If the result exceeds 2^CODE_W-1, set the sticky ovf flag; acc is frozen from then on.
//    Acc width is CODE_W+4, so it cannot wrap before ovf is set.
//  - COLLECT, digit with cnt==MAX_DIGITS: entry_error pulse, then IDLE.
//  - COLLECT, CLEAR: return to IDLE, no error.
//  - COLLECT, ENTER: if ovf, entry_error pulse and IDLE; otherwise SEND.
//  - COLLECT, no key: timer++. When timer==TIMEOUT_CYC-1: entry_error pulse, IDLE.
//    A key in that same cycle takes priority over the timeout.
//  - SEND: while door_busy=1, wait. On the first edge with door_busy=0:
//    validate_code=1 for one cycle, access_code<=acc[CODE_W-1:0], then HOLD.
//  - Latency: ENTER sampled at edge N -> SEND. With door_busy=0, validate_code is high
//    from edge N+1 to edge N+2.
//  - HOLD: all keys ignored. Count HOLD_CYC cycles, then IDLE.
//  - Only one of validate_code and entry_error is high in any cycle.
//  - key_valid held high for k cycles counts as k keys; the scanner must debounce.
// STRUCTURE
//  - Shared package access_pkg: state encoding (2-bit localparams IDLE/COLLECT/SEND/HOLD),
//    KEY_CLEAR=4'hA, KEY_ENTER=4'hB. The door FSM imports the same package.
//  - Sub-module entry_timer: a down-counter with load and clear, reused for both the
//    timeout and HOLD counts. Width = clog2(max(TIMEOUT_CYC, HOLD_CYC)+1).
//  - Top level: next-state logic, digit accumulator, ovf flag, output registers.
// TESTING
//  1 keys 0,7,ENTER, door_busy=0 -> validate_code pulse 1 cycle after ENTER,
//    access_code=7; keys during the next 4 cycles are ignored.
//  2 keys 1,6,ENTER (16 > 15) -> entry_error pulse, no validate_code, access_code unchanged.
//  3 keys 1,2,3 -> entry_error on the third digit, state IDLE.
//  4 key 5, then 255 idle cycles -> entry_error, IDLE. Key 5 at idle cycle 254 -> no error.
//  5 keys 9,ENTER with door_busy=1 for 10 cycles -> validate_code 1 cycle after door_busy
//    falls, access_code=9.
//  6 key 1, CLEAR, key 4, ENTER -> access_code=4. Reset asserted after key 3 -> no pulse,
//    all outputs 0.

Source files
------------

// File: rtl/access_pkg.sv
// Shared definitions for the access gate: FSM state encoding and special key codes.
// The door FSM imports this package as well.
package access_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] SEND    = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_COLLECT = COLLECT,
    ST_SEND    = SEND,
    ST_HOLD    = HOLD
  } state_t;

  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
  localparam logic [3:0] KEY_CLEAR     = 4'hA;
  localparam logic [3:0] KEY_ENTER     = 4'hB;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/entry_timer.sv
// Down-counter with clear and load; shared between the inter-key timeout and the
// post-validate hold window. Priority: clear, then load, then decrement (stops at 0).
module entry_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         is_zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign is_zero = (count_reg == '0);

endmodule

// File: rtl/access_code_entry.sv
// Keypad front-end: collects decimal digits into a binary code and hands it to the
// door FSM as a one-cycle validate_code pulse, with overflow/excess-digit/timeout errors.
module access_code_entry
  import access_pkg::*;
#(
  parameter int CODE_W      = 4,
  parameter int MAX_DIGITS  = 2,
  parameter int TIMEOUT_CYC = 255,
  parameter int HOLD_CYC    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  input  logic              door_busy,
  output logic              validate_code,
  output logic [CODE_W-1:0] access_code,
  output logic              entry_error,
  output logic [1:0]        state_out
);

  localparam int ACC_W  = CODE_W + 4;
  localparam int STEP_W = ACC_W + 4;
  localparam int CNT_W  = $clog2(MAX_DIGITS + 1);
  localparam int TMR_W  = $clog2(max_int(TIMEOUT_CYC, HOLD_CYC) + 1);

  localparam logic [ACC_W-1:0]  ACC_MAX   = ACC_W'((1 << CODE_W) - 1);
  localparam logic [STEP_W-1:0] STEP_MAX  = STEP_W'((1 << CODE_W) - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_DIGITS);
  localparam logic [TMR_W-1:0]  TO_LOAD   = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0]  HOLD_LOAD = TMR_W'(HOLD_CYC - 1);

  state_t            state_reg;
  logic [ACC_W-1:0]  acc_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              ovf_reg;
  logic              validate_code_reg;
  logic              entry_error_reg;
  logic [CODE_W-1:0] access_code_reg;

  logic              key_digit;
  logic              key_clear;
  logic              key_enter;
  logic [STEP_W-1:0] acc_step;

  logic              tmr_clear;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_load_val;
  logic              tmr_dec;
  logic              tmr_zero;

  // Codes C-F are not keys at all: in COLLECT they count as an idle cycle.
  assign key_digit = key_valid && (key_code <= KEY_DIGIT_MAX);
  assign key_clear = key_valid && (key_code == KEY_CLEAR);
  assign key_enter = key_valid && (key_code == KEY_ENTER);

  assign acc_step = STEP_W'(acc_reg) * STEP_W'(10) + STEP_W'(key_code);

  always_comb begin
    tmr_clear    = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = TO_LOAD;
    tmr_dec      = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (key_digit && !door_busy) tmr_load  = 1'b1;
        else                         tmr_clear = 1'b1;
      end
      ST_COLLECT: begin
        if (key_digit && (cnt_reg < CNT_MAX))        tmr_load  = 1'b1;
        else if (key_digit || key_clear || key_enter) tmr_clear = 1'b1;
        else if (tmr_zero)                            tmr_clear = 1'b1;
        else                                          tmr_dec   = 1'b1;
      end
      ST_SEND: begin
        if (!door_busy) begin
          tmr_load     = 1'b1;
          tmr_load_val = HOLD_LOAD;
        end
      end
      ST_HOLD: tmr_dec = 1'b1;
      default: tmr_clear = 1'b1;
    endcase
  end

  entry_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (tmr_clear),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .is_zero  (tmr_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg         <= ST_IDLE;
      acc_reg           <= '0;
      cnt_reg           <= '0;
      ovf_reg           <= 1'b0;
      validate_code_reg <= 1'b0;
      entry_error_reg   <= 1'b0;
      access_code_reg   <= '0;
    end else begin
      validate_code_reg <= 1'b0;
      entry_error_reg   <= 1'b0;
      unique case (state_reg)
        ST_IDLE: begin
          if (key_digit && !door_busy) begin
            acc_reg   <= ACC_W'(key_code);
            cnt_reg   <= CNT_W'(1);
            ovf_reg   <= (ACC_W'(key_code) > ACC_MAX);
            state_reg <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (key_digit) begin
            if (cnt_reg < CNT_MAX) begin
              // Once overflowed the accumulator is frozen so it can never wrap.
              if (!ovf_reg) begin
                acc_reg <= acc_step[ACC_W-1:0];
                if (acc_step > STEP_MAX) ovf_reg <= 1'b1;
              end
              cnt_reg <= cnt_reg + CNT_W'(1);
            end else begin
              entry_error_reg <= 1'b1;
              state_reg       <= ST_IDLE;
            end
          end else if (key_clear) begin
            state_reg <= ST_IDLE;
          end else if (key_enter) begin
            if (ovf_reg) begin
              entry_error_reg <= 1'b1;
              state_reg       <= ST_IDLE;
            end else begin
              state_reg <= ST_SEND;
            end
          end else if (tmr_zero) begin
            entry_error_reg <= 1'b1;
            state_reg       <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (!door_busy) begin
            validate_code_reg <= 1'b1;
            access_code_reg   <= acc_reg[CODE_W-1:0];
            state_reg         <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (tmr_zero) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign validate_code = validate_code_reg;
  assign entry_error   = entry_error_reg;
  assign access_code   = access_code_reg;
  assign state_out     = state_reg;

endmodule

// File: tb/tb_access_code_entry.sv
// Directed bench for access_code_entry: an integer-level reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_access_code_entry;

  localparam int CODE_W      = 4;
  localparam int MAX_DIGITS  = 2;
  localparam int TIMEOUT_CYC = 255;
  localparam int HOLD_CYC    = 4;
  localparam int CODE_LIMIT  = (1 << CODE_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              key_valid;
  logic [3:0]        key_code;
  logic              door_busy;
  logic              validate_code;
  logic [CODE_W-1:0] access_code;
  logic              entry_error;
  logic [1:0]        state_out;

  int checks   = 0;
  int failures = 0;
  int n_valid  = 0;
  int n_err    = 0;

  access_code_entry #(
    .CODE_W      (CODE_W),
    .MAX_DIGITS  (MAX_DIGITS),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .HOLD_CYC    (HOLD_CYC)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .door_busy     (door_busy),
    .validate_code (validate_code),
    .access_code   (access_code),
    .entry_error   (entry_error),
    .state_out     (state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 collecting, 2 waiting to send, 3 hold window.
  int          m_phase, m_val, m_digits, m_idle, m_hold;
  logic        m_valid, m_err;
  logic [3:0]  m_code;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase <= 0; m_val <= 0; m_digits <= 0; m_idle <= 0; m_hold <= 0;
      m_valid <= 1'b0; m_err <= 1'b0; m_code <= 4'd0;
    end else begin
      m_valid <= 1'b0;
      m_err   <= 1'b0;
      case (m_phase)
        0: if (key_valid && key_code <= 9 && !door_busy) begin
             m_val <= int'(key_code); m_digits <= 1; m_idle <= 0; m_phase <= 1;
           end
        1: if (key_valid && key_code <= 9) begin
             if (m_digits < MAX_DIGITS) begin
               m_val <= m_val * 10 + int'(key_code); m_digits <= m_digits + 1; m_idle <= 0;
             end else begin
               m_err <= 1'b1; m_phase <= 0;
             end
           end else if (key_valid && key_code == 4'hA) begin
             m_phase <= 0;
           end else if (key_valid && key_code == 4'hB) begin
             if (m_val > CODE_LIMIT) begin m_err <= 1'b1; m_phase <= 0; end
             else m_phase <= 2;
           end else if (m_idle == TIMEOUT_CYC - 1) begin
             m_err <= 1'b1; m_phase <= 0;
           end else begin
             m_idle <= m_idle + 1;
           end
        2: if (!door_busy) begin
             m_valid <= 1'b1; m_code <= 4'(m_val); m_phase <= 3; m_hold <= 0;
           end
        default: if (m_hold == HOLD_CYC - 1) m_phase <= 0; else m_hold <= m_hold + 1;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("cyc_validate_code", int'(validate_code), int'(m_valid));
    chk("cyc_entry_error",   int'(entry_error),   int'(m_err));
    chk("cyc_access_code",   int'(access_code),   int'(m_code));
    chk("cyc_state",         int'(state_out),     m_phase);
    if (validate_code) n_valid++;
    if (entry_error)   n_err++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    #1;
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  int v0, e0;

  task automatic mark();
    v0 = n_valid;
    e0 = n_err;
  endtask

  initial begin
    reset_n = 1'b0; key_valid = 1'b0; key_code = 4'h0; door_busy = 1'b0;
    idle(2);
    chk("rst_validate", int'(validate_code), 0);
    chk("rst_access",   int'(access_code),   0);
    chk("rst_error",    int'(entry_error),   0);
    chk("rst_state",    int'(state_out),     0);
    reset_n = 1'b1;
    idle(2);

    // 1: 0,7,ENTER -> 7; keys during the following 4 cycles are ignored
    mark();
    press(4'd0); press(4'd7); press(4'hB);
    key_valid = 1'b1; key_code = 4'd3;
    idle(1);
    chk("t1_validate_next_cycle", int'(validate_code), 1);
    chk("t1_access_code", int'(access_code), 7);
    idle(3);
    key_valid = 1'b0;
    idle(3);
    chk("t1_state_idle", int'(state_out), 0);
    chk("t1_pulses", n_valid - v0, 1);
    chk("t1_errors", n_err - e0, 0);
    $display("T1 code 07 -> access_code=%0d", access_code);

    // 2: 16 overflows
    mark();
    press(4'd1); press(4'd6); press(4'hB);
    idle(2);
    chk("t2_errors", n_err - e0, 1);
    chk("t2_pulses", n_valid - v0, 0);
    chk("t2_access_kept", int'(access_code), 7);
    $display("T2 code 16 -> errors=%0d", n_err - e0);

    // 3: third digit is an excess digit
    mark();
    press(4'd1); press(4'd2); press(4'd3);
    idle(1);
    chk("t3_errors", n_err - e0, 1);
    chk("t3_state", int'(state_out), 0);
    $display("T3 digits 123 -> errors=%0d", n_err - e0);

    // 4: timeout boundary, then a key on the last idle cycle rescues the entry
    mark();
    press(4'd5);
    idle(TIMEOUT_CYC - 1);
    chk("t4_no_error_yet", n_err - e0, 0);
    chk("t4_still_collect", int'(state_out), 1);
    idle(1);
    chk("t4_timeout_error", n_err - e0, 1);
    chk("t4_state_idle", int'(state_out), 0);
    mark();
    press(4'd1);
    idle(TIMEOUT_CYC - 1);
    press(4'd0);
    chk("t4b_no_error", n_err - e0, 0);
    chk("t4b_collect", int'(state_out), 1);
    press(4'hB);
    idle(6);
    chk("t4b_access", int'(access_code), 10);
    chk("t4b_pulses", n_valid - v0, 1);
    $display("T4 timeout errors=%0d, late key code=%0d", e0 - (n_err - 1), access_code);

    // 5: door busy blocks entry start and hand-off
    mark();
    door_busy = 1'b1;
    press(4'd4);
    chk("t5_busy_ignored", int'(state_out), 0);
    door_busy = 1'b0;
    press(4'd9);
    door_busy = 1'b1;
    press(4'hB);
    idle(9);
    chk("t5_waiting", n_valid - v0, 0);
    chk("t5_state_send", int'(state_out), 2);
    door_busy = 1'b0;
    idle(1);
    chk("t5_validate", int'(validate_code), 1);
    chk("t5_access", int'(access_code), 9);
    idle(5);
    $display("T5 busy hand-off -> access_code=%0d", access_code);

    // 6: CLEAR restarts, then reset mid-entry drops the partial code
    mark();
    press(4'd1); press(4'hA); press(4'd4); press(4'hB);
    idle(6);
    chk("t6_access", int'(access_code), 4);
    chk("t6_pulses", n_valid - v0, 1);
    mark();
    press(4'd3);
    reset_n = 1'b0;
    idle(1);
    chk("t6_rst_validate", int'(validate_code), 0);
    chk("t6_rst_access", int'(access_code), 0);
    chk("t6_rst_state", int'(state_out), 0);
    reset_n = 1'b1;
    idle(4);
    chk("t6_no_pulse", n_valid - v0, 0);
    chk("t6_no_error", n_err - e0, 0);
    $display("T6 clear/reset -> access_code=%0d", access_code);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
